// File: rtl/dma_bus_master.sv
// dma_bus_master: 6502 bus initiator that halts the CPU, copies len bytes src->dst, then returns the bus
//   clk_96mhz/reset      system clock, synchronous active-high reset
//   clk_1mhz/cpu_rwb_in  asynchronous phi2 and CPU RWB, synchronised internally
//   start/src/dst/len    transfer request, operands latched on an accepted start
//   abort                level; the current bus cycle completes, then the bus is released
//   rd_data              data bus value captured at the end of a read cycle
//   cpu_rdy/cpu_be       CPU halt and bus-enable controls
//   m_*                  master address/data/rwb and their pad enables
//   busy/done/remaining  transfer status
module dma_bus_master #(
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk_96mhz,
    input  logic              reset,
    input  logic              clk_1mhz,
    input  logic              cpu_rwb_in,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic [7:0]        rd_data,
    output logic              cpu_rdy,
    output logic              cpu_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_addr_oe,
    output logic              m_rwb,
    output logic [7:0]        m_data,
    output logic              m_data_oe,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  remaining
);
    localparam int CW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, HALT, DRAIN, RD, WR, RELEASE} state_t;

    state_t            state_q;
    logic [2:0]        phi_q;
    logic [1:0]        rwb_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CW-1:0]     cnt_q;
    logic              fall;

    // phi_q[1:0] is the two-flop synchroniser, phi_q[2] the edge register
    assign fall = phi_q[2] & ~phi_q[1];

    always_ff @(posedge clk_96mhz) begin
        if (reset) begin
            phi_q <= '0;
            rwb_q <= 2'b11;
        end else begin
            phi_q <= {phi_q[1:0], clk_1mhz};
            rwb_q <= {rwb_q[0], cpu_rwb_in};
        end
    end

    always_ff @(posedge clk_96mhz) begin
        if (reset) begin
            state_q   <= IDLE;
            cpu_rdy   <= 1'b1;
            cpu_be    <= 1'b1;
            m_addr    <= '0;
            m_addr_oe <= 1'b0;
            m_rwb     <= 1'b1;
            m_data    <= '0;
            m_data_oe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (len != '0) begin
                        state_q   <= HALT;
                        src_q     <= src_addr;
                        dst_q     <= dst_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        cpu_rdy   <= 1'b0;
                    end else begin
                        done <= 1'b1;
                    end
                end
                // the CPU only honours RDY during a read, so wait for a read fall before BE drops
                HALT: if (fall) begin
                    if (abort) begin
                        state_q <= RELEASE;
                    end else if (rwb_q[1]) begin
                        state_q <= DRAIN;
                        cpu_be  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                DRAIN: if (fall) begin
                    if (abort) begin
                        state_q <= RELEASE;
                        cpu_be  <= 1'b1;
                    end else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                        state_q   <= RD;
                        m_addr    <= src_q;
                        m_rwb     <= 1'b1;
                        m_addr_oe <= 1'b1;
                        m_data_oe <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD: if (fall) begin
                    m_data <= rd_data;
                    src_q  <= src_q + 1'b1;
                    if (abort) begin
                        state_q   <= RELEASE;
                        m_addr_oe <= 1'b0;
                        m_rwb     <= 1'b1;
                        cpu_be    <= 1'b1;
                    end else begin
                        state_q   <= WR;
                        m_addr    <= dst_q;
                        m_rwb     <= 1'b0;
                        m_data_oe <= 1'b1;
                    end
                end
                WR: if (fall) begin
                    dst_q     <= dst_q + 1'b1;
                    remaining <= remaining - 1'b1;
                    m_data_oe <= 1'b0;
                    if (remaining == LEN_W'(1) || abort) begin
                        state_q   <= RELEASE;
                        m_addr_oe <= 1'b0;
                        m_rwb     <= 1'b1;
                        cpu_be    <= 1'b1;
                    end else begin
                        state_q <= RD;
                        m_addr  <= src_q;
                        m_rwb   <= 1'b1;
                    end
                end
                RELEASE: if (fall) begin
                    state_q <= IDLE;
                    cpu_rdy <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
